// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
//   Collects operand A, operand B and an opcode over three byte transfers on
//   a narrow input bus, holds them on the ALU operand ports for one execute
//   cycle, registers the ALU result/carry and offers it on a valid/ready
//   output handshake. Transactions stalled between bytes are dropped after
//   TIMEOUT idle cycles; abort cancels from any state.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_A    | idle, waiting for operand A byte
//   S_B    | waiting for operand B byte (idle timer running)
//   S_OP   | waiting for opcode byte (idle timer running)
//   S_EXEC | operands stable at the ALU, result captured at closing edge
//   S_RES  | result held on res_* until res_ready
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   din, din_valid/din_ready serial byte input handshake
//   abort                    synchronous transaction cancel
//   alu_a, alu_b, alu_sel    registered operands/opcode to the ALU
//   alu_result, alu_cout     combinational ALU outputs
//   res_data, res_cout       registered result and carry
//   res_valid/res_ready      result handshake
//   busy                     transaction in progress
//   timeout_err              one-cycle pulse when a transaction times out
// ---------------------------------------------------------------------------
module alu_operand_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic          accept;
    logic          idle_active;
    logic          idle_expire;
    logic [CW:0]   idle_inc;
    logic [CW-1:0] idle_cnt, idle_cnt_nxt;

    assign din_ready = (state == S_A) || (state == S_B) || (state == S_OP);
    assign busy      = (state != S_A);

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = '0;
        accept       = din_valid && din_ready;
        idle_active  = (state == S_B) || (state == S_OP);
        idle_inc     = {1'b0, idle_cnt} + (CW+1)'(1);
        // Expiry is judged on the count this idle cycle would reach, so a
        // byte arriving in that same cycle still wins.
        idle_expire  = idle_active && !accept && (idle_inc == (CW+1)'(TIMEOUT));

        case (state)
            S_A:     if (accept) state_nxt = S_B;
            S_B:     if (accept) state_nxt = S_OP;   else if (idle_expire) state_nxt = S_A;
            S_OP:    if (accept) state_nxt = S_EXEC; else if (idle_expire) state_nxt = S_A;
            S_EXEC:  state_nxt = S_RES;
            S_RES:   if (res_ready) state_nxt = S_A;
            default: state_nxt = S_A;
        endcase

        if (idle_active && !accept && !idle_expire) begin
            idle_cnt_nxt = idle_inc[CW-1:0];
        end

        if (abort) begin
            state_nxt    = S_A;
            idle_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_A;
            idle_cnt    <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            res_data    <= '0;
            res_cout    <= 1'b0;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            idle_cnt    <= idle_cnt_nxt;
            timeout_err <= idle_expire && !abort;

            if (accept && !abort) begin
                if (state == S_A)  alu_a   <= din;
                if (state == S_B)  alu_b   <= din;
                if (state == S_OP) alu_sel <= din[2:0];
            end

            if (abort) begin
                res_valid <= 1'b0;
            end else if (state == S_EXEC) begin
                res_data  <= alu_result;
                res_cout  <= alu_cout;
                res_valid <= 1'b1;
            end else if ((state == S_RES) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    localparam int W  = 8;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         abort;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_sel;
    logic [W-1:0] alu_result;
    logic         alu_cout;
    logic [W-1:0] res_data;
    logic         res_cout;
    logic         res_valid;
    logic         res_ready;
    logic         busy;
    logic         timeout_err;

    alu_operand_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .abort       (abort),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .res_data    (res_data),
        .res_cout    (res_cout),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Small ALU: {carry, result}
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {1'b0, a} + {1'b0, b} + 9'd1;
            default: return {a, 1'b0};
        endcase
    endfunction

    assign {alu_cout, alu_result} = alu_f(alu_a, alu_b, alu_sel);

    int n_checks = 0;
    int n_fail   = 0;
    int n_terr   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Transaction-level reference: how many bytes are collected, whether an
    // execute or a held result is pending, and the idle-cycle tally.
    int         m_n;
    bit         m_exec, m_hold;
    int         m_idle;
    logic [7:0] m_a, m_b, m_res;
    logic [2:0] m_sel;
    logic       m_cout, m_valid, m_terr;

    task automatic model_reset();
        m_n = 0; m_exec = 0; m_hold = 0; m_idle = 0;
        m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_cout = 0;
        m_valid = 0; m_terr = 0;
    endtask

    task automatic model_step();
        logic [8:0] r;
        m_terr = 0;
        if (abort) begin
            m_n = 0; m_exec = 0; m_hold = 0; m_valid = 0; m_idle = 0;
        end else if (m_exec) begin
            r = alu_f(m_a, m_b, m_sel);
            m_res = r[7:0]; m_cout = r[8]; m_valid = 1;
            m_exec = 0; m_hold = 1;
        end else if (m_hold) begin
            if (res_ready) begin
                m_valid = 0; m_hold = 0;
            end
        end else if (din_valid) begin
            if (m_n == 0) m_a = din;
            else if (m_n == 1) m_b = din;
            else m_sel = din[2:0];
            m_n++;
            m_idle = 0;
            if (m_n == 3) begin
                m_n = 0; m_exec = 1;
            end
        end else if (m_n > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                m_n = 0; m_idle = 0; m_terr = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("din_ready",   32'(din_ready),   32'(!(m_exec || m_hold)));
        chk("busy",        32'(busy),        32'((m_n != 0) || m_exec || m_hold));
        chk("alu_a",       32'(alu_a),       32'(m_a));
        chk("alu_b",       32'(alu_b),       32'(m_b));
        chk("alu_sel",     32'(alu_sel),     32'(m_sel));
        chk("res_valid",   32'(res_valid),   32'(m_valid));
        chk("res_data",    32'(res_data),    32'(m_res));
        chk("res_cout",    32'(res_cout),    32'(m_cout));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic cycle(input logic dv, input logic [7:0] d, input logic ab, input logic rr);
        din_valid = dv; din = d; abort = ab; res_ready = rr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        if (timeout_err) n_terr++;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, rr);
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 0; abort = 0; res_ready = 0;
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Basic transaction
        cycle(1, 8'h3C, 0, 1);
        cycle(1, 8'h05, 0, 1);
        cycle(1, 8'h00, 0, 1);
        chk("basic_a",   32'(alu_a),     32'h3C);
        chk("basic_b",   32'(alu_b),     32'h05);
        chk("basic_exec_novalid", 32'(res_valid), 32'd0);
        cycle(0, 8'h00, 0, 1);
        chk("basic_valid", 32'(res_valid), 32'd1);
        chk("basic_data",  32'(res_data),  32'h41);
        chk("basic_cout",  32'(res_cout),  32'd0);
        cycle(0, 8'h00, 0, 1);
        chk("basic_valid_drop", 32'(res_valid), 32'd0);

        // Carry and backpressure; bytes offered during the hold are refused
        cycle(1, 8'hFF, 0, 0);
        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 8'hA5, 0, 0);
            if (i > 0) begin
                chk("bp_valid", 32'(res_valid), 32'd1);
                chk("bp_data",  32'(res_data),  32'h00);
                chk("bp_cout",  32'(res_cout),  32'd1);
                chk("bp_ready", 32'(din_ready), 32'd0);
            end
        end
        cycle(1, 8'hA5, 0, 1);
        chk("bp_release_valid", 32'(res_valid), 32'd0);
        chk("bp_release_ready", 32'(din_ready), 32'd1);
        chk("bp_a_not_taken",   32'(alu_a),     32'hFF);

        // Opcode masking with gaps below the timeout
        n_terr = 0;
        cycle(1, 8'h9A, 0, 1); idle(3, 1);
        cycle(1, 8'h17, 0, 1); idle(3, 1);
        cycle(1, 8'hFD, 0, 1);
        chk("mask_sel", 32'(alu_sel), 32'd5);
        idle(2, 1);
        chk("gap_no_timeout", 32'(n_terr), 32'd0);

        // Timeout after TO idle cycles
        cycle(1, 8'h11, 0, 1);
        idle(3, 1);
        chk("to_not_yet", 32'(timeout_err), 32'd0);
        idle(1, 1);
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_busy",  32'(busy),        32'd0);
        chk("to_a",     32'(alu_a),       32'h11);
        idle(1, 1);
        chk("to_pulse_end", 32'(timeout_err), 32'd0);

        // Byte on the last idle cycle wins
        cycle(1, 8'h22, 0, 1);
        idle(3, 1);
        cycle(1, 8'h33, 0, 1);
        chk("to_edge_b",    32'(alu_b),       32'h33);
        chk("to_edge_busy", 32'(busy),        32'd1);
        chk("to_edge_nerr", 32'(timeout_err), 32'd0);

        // Abort together with the opcode byte
        cycle(1, 8'h07, 1, 1);
        chk("abort_sel",   32'(alu_sel),   32'd5);
        chk("abort_ready", 32'(din_ready), 32'd1);
        chk("abort_busy",  32'(busy),      32'd0);
        idle(2, 1);
        chk("abort_novalid", 32'(res_valid), 32'd0);

        // Abort during the result hold
        cycle(1, 8'h40, 0, 0);
        cycle(1, 8'h02, 0, 0);
        cycle(1, 8'h01, 0, 0);
        idle(2, 0);
        chk("abort_res_valid", 32'(res_valid), 32'd1);
        cycle(0, 8'h00, 1, 0);
        chk("abort_res_drop", 32'(res_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
        end

        // Async reset while a result is held
        cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h5A, 0, 0);
        cycle(1, 8'h66, 0, 0);
        cycle(1, 8'h00, 0, 0);
        idle(2, 0);
        chk("pre_rst_valid", 32'(res_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data",  32'(res_data),  32'd0);
        chk("rst_a",     32'(alu_a),     32'd0);
        chk("rst_ready", 32'(din_ready), 32'd1);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        cycle(1, 8'h10, 0, 1);
        cycle(1, 8'h20, 0, 1);
        cycle(1, 8'h04, 0, 1);
        idle(2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
